// File: rtl/ctrl_decode_stage_if.sv
// -----------------------------------------------------------------------------
// ctrl_decode_stage_if
//   Bundles the fetch-side handshake, the issue-side handshake and the decoded
//   control outputs of ctrl_decode_stage.
//
//   master : upstream/downstream environment (drives in_valid, ir, flush,
//            out_ready; observes everything else)
//   slave  : the decode stage itself
//
//   in_valid / in_ready / ir       fetch handshake and instruction word
//   flush                          squash held and incoming instruction
//   out_valid / out_ready / out_ir issue handshake and registered ir copy
//   i_r, write_reg_en, regfile_src_oalu_st, ALU_inst, jump, br_inst,
//   wr_en_stk, fen, flopinst       registered control bundle
//   mul_busy                       MUL issue-stall counter non-zero
// -----------------------------------------------------------------------------
interface ctrl_decode_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] ir;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_ir;
   logic            i_r;
   logic            write_reg_en;
   logic            regfile_src_oalu_st;
   logic [3:0]      ALU_inst;
   logic            jump;
   logic            br_inst;
   logic            wr_en_stk;
   logic            fen;
   logic [1:0]      flopinst;
   logic            mul_busy;

   modport master (
      output in_valid, ir, flush, out_ready,
      input  in_ready, out_valid, out_ir, i_r, write_reg_en,
             regfile_src_oalu_st, ALU_inst, jump, br_inst, wr_en_stk,
             fen, flopinst, mul_busy
   );

   modport slave (
      input  in_valid, ir, flush, out_ready,
      output in_ready, out_valid, out_ir, i_r, write_reg_en,
             regfile_src_oalu_st, ALU_inst, jump, br_inst, wr_en_stk,
             fen, flopinst, mul_busy
   );
endinterface

// File: rtl/ctrl_decode_stage.sv
// -----------------------------------------------------------------------------
// ctrl_decode_stage
//   Registered control decoder between instruction fetch and register-file/ALU
//   issue. One instruction word is accepted per valid/ready handshake, decoded
//   into the core control bundle and held in a single pipeline register.
//   A branch/jump redirect flushes the held and incoming instruction. An
//   accepted MUL blocks further accepts for MUL_LAT-1 cycles.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous reset, active low
//     bus    ctrl_decode_stage_if.slave (handshakes + control bundle)
//
//   Instruction fields: class = ir[XLEN-1:XLEN-3], func = ir[XLEN-4:XLEN-5].
// -----------------------------------------------------------------------------
module ctrl_decode_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   ctrl_decode_stage_if.slave bus
);

   localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

   typedef enum logic [2:0] {
      CLS_ARITH   = 3'd0,
      CLS_DATA    = 3'd1,
      CLS_BRANCH  = 3'd2,
      CLS_JUMP    = 3'd3,
      CLS_COMPARE = 3'd4,
      CLS_FLOAT   = 3'd5,
      CLS_LOGIC   = 3'd6,
      CLS_SHIFT   = 3'd7
   } cls_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_ADDU = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SUBU = 4'd3,
      ALU_NAND = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_MUL  = 4'd6,
      ALU_SH0  = 4'd7,
      ALU_SH1  = 4'd8,
      ALU_SH2  = 4'd9,
      ALU_SH3  = 4'd10,
      ALU_LT   = 4'd11,
      ALU_EQ   = 4'd12,
      ALU_NE   = 4'd13,
      ALU_LTU  = 4'd14,
      ALU_RSV  = 4'd15
   } alu_e;

   typedef struct packed {
      logic       i_r;
      logic       wr;
      logic       src;
      alu_e       alu;
      logic       jump;
      logic       br;
      logic       stk;
      logic       fen;
      logic [1:0] fp;
   } ctrl_t;

   cls_e            cls;
   logic [1:0]      func;
   logic            is_mul;
   logic            accept;
   ctrl_t           ctrl_d;
   ctrl_t           ctrl_q;
   logic [XLEN-1:0] out_ir_q;
   logic            out_valid_q;
   logic [CW-1:0]   stall_q;

   assign cls    = cls_e'(bus.ir[XLEN-1 -: 3]);
   assign func   = bus.ir[XLEN-4 -: 2];
   assign is_mul = (cls == CLS_ARITH) && (func == 2'd3);

   assign bus.in_ready = (!out_valid_q || bus.out_ready) && (stall_q == '0) && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // Decode: every field starts at zero so unlisted outputs are never X.
   always_comb begin
      ctrl_d = '0;
      case (cls)
         CLS_ARITH: begin
            ctrl_d.wr = 1'b1;
            case (func)
               2'd0:    begin ctrl_d.alu = ALU_ADD;  ctrl_d.i_r = 1'b1; end
               2'd1:    begin ctrl_d.alu = ALU_ADD;  ctrl_d.i_r = 1'b0; end
               2'd2:    begin ctrl_d.alu = ALU_ADDU; ctrl_d.i_r = 1'b1; end
               default: begin ctrl_d.alu = ALU_MUL;  ctrl_d.i_r = 1'b1; end
            endcase
         end
         CLS_DATA: begin
            case (func)
               2'd0:    begin ctrl_d.src = 1'b1; ctrl_d.wr = 1'b1; end
               2'd1:    begin ctrl_d.src = 1'b1; ctrl_d.stk = 1'b1; end
               2'd2:    begin ctrl_d.src = 1'b1; ctrl_d.wr = 1'b1; end
               default: begin ctrl_d.alu = ALU_SUB; ctrl_d.i_r = 1'b1; ctrl_d.wr = 1'b1; end
            endcase
         end
         CLS_BRANCH: begin
            ctrl_d.br  = 1'b1;
            ctrl_d.i_r = 1'b1;
            case (func)
               2'd0:    ctrl_d.alu = ALU_EQ;
               2'd1:    ctrl_d.alu = ALU_NE;
               2'd2:    ctrl_d.alu = ALU_LT;
               default: ctrl_d.alu = ALU_LTU;
            endcase
         end
         CLS_JUMP: begin
            ctrl_d.jump = 1'b1;
         end
         CLS_COMPARE: begin
            ctrl_d.wr = 1'b1;
            case (func)
               2'd0:    begin ctrl_d.alu = ALU_LT;   ctrl_d.i_r = 1'b1; end
               2'd1:    begin ctrl_d.alu = ALU_LT;   ctrl_d.i_r = 1'b0; end
               2'd2:    begin ctrl_d.alu = ALU_EQ;   ctrl_d.i_r = 1'b0; end
               default: begin ctrl_d.alu = ALU_SUBU; ctrl_d.i_r = 1'b1; end
            endcase
         end
         CLS_FLOAT: begin
            ctrl_d.fen = 1'b1;
            ctrl_d.fp  = func;
         end
         CLS_LOGIC: begin
            ctrl_d.wr = 1'b1;
            case (func)
               2'd0:    begin ctrl_d.alu = ALU_NAND; ctrl_d.i_r = 1'b1; end
               2'd1:    begin ctrl_d.alu = ALU_NOR;  ctrl_d.i_r = 1'b1; end
               2'd2:    begin ctrl_d.alu = ALU_NAND; ctrl_d.i_r = 1'b0; end
               default: begin ctrl_d.alu = ALU_NOR;  ctrl_d.i_r = 1'b0; end
            endcase
         end
         default: begin
            ctrl_d.wr = 1'b1;
            case (func)
               2'd0:    ctrl_d.alu = ALU_SH0;
               2'd1:    ctrl_d.alu = ALU_SH1;
               2'd2:    ctrl_d.alu = ALU_SH2;
               default: ctrl_d.alu = ALU_SH3;
            endcase
         end
      endcase
   end

   // Flush outranks accept/drain; the bundle itself is left untouched so the
   // outputs simply hold their last values behind out_valid=0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         stall_q     <= '0;
         ctrl_q      <= '0;
         out_ir_q    <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            ctrl_q      <= ctrl_d;
            out_ir_q    <= bus.ir;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (accept && is_mul) begin
            stall_q <= MUL_LOAD;
         end else if (stall_q != '0) begin
            stall_q <= stall_q - CW'(1);
         end
      end
   end

   assign bus.out_valid           = out_valid_q;
   assign bus.out_ir              = out_ir_q;
   assign bus.i_r                 = ctrl_q.i_r;
   assign bus.write_reg_en        = ctrl_q.wr;
   assign bus.regfile_src_oalu_st = ctrl_q.src;
   assign bus.ALU_inst            = ctrl_q.alu;
   assign bus.jump                = ctrl_q.jump;
   assign bus.br_inst             = ctrl_q.br;
   assign bus.wr_en_stk           = ctrl_q.stk;
   assign bus.fen                 = ctrl_q.fen;
   assign bus.flopinst            = ctrl_q.fp;
   assign bus.mul_busy            = (stall_q != '0);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_ctrl_decode_stage
//   Scoreboard bench for ctrl_decode_stage (XLEN=32, MUL_LAT=3). Expected
//   bundles come from a reference decode of the driven ir and are pushed on
//   accept, popped when the stage hands a bundle downstream.
// -----------------------------------------------------------------------------
module tb_ctrl_decode_stage;

   localparam int XLEN = 32;
   localparam int BW   = XLEN + 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ctrl_decode_stage_if #(.XLEN(XLEN)) bus ();

   ctrl_decode_stage #(.XLEN(XLEN), .MUL_LAT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [BW-1:0] sb_q[$];
   logic [BW-1:0] exp_b;

   // {out_ir, i_r, wr, src, alu[3:0], jump, br, stk, fen, flopinst[1:0]}
   function automatic logic [BW-1:0] act();
      act = {bus.out_ir, bus.i_r, bus.write_reg_en, bus.regfile_src_oalu_st,
             bus.ALU_inst, bus.jump, bus.br_inst, bus.wr_en_stk, bus.fen,
             bus.flopinst};
   endfunction

   function automatic logic [BW-1:0] model(input logic [XLEN-1:0] ir);
      logic [2:0] c;
      logic [1:0] f;
      logic ir_b, wr, src, j, br, stk, fe;
      logic [3:0] alu;
      logic [1:0] fp;
      c = ir[31:29];
      f = ir[28:27];
      {ir_b, wr, src, j, br, stk, fe, alu, fp} = '0;
      case (c)
         3'd0: begin wr = 1'b1; ir_b = (f != 2'd1);
                     alu = (f == 2'd2) ? 4'd1 : (f == 2'd3) ? 4'd6 : 4'd0; end
         3'd1: begin src = (f != 2'd3); wr = (f != 2'd1); stk = (f == 2'd1);
                     ir_b = (f == 2'd3); alu = (f == 2'd3) ? 4'd2 : 4'd0; end
         3'd2: begin br = 1'b1; ir_b = 1'b1;
                     alu = (f == 2'd0) ? 4'd12 : (f == 2'd1) ? 4'd13 : (f == 2'd2) ? 4'd11 : 4'd14; end
         3'd3: j = 1'b1;
         3'd4: begin wr = 1'b1; ir_b = (f == 2'd0) || (f == 2'd3);
                     alu = (f == 2'd3) ? 4'd3 : (f == 2'd2) ? 4'd12 : 4'd11; end
         3'd5: begin fe = 1'b1; fp = f; end
         3'd6: begin wr = 1'b1; ir_b = (f < 2'd2); alu = f[0] ? 4'd5 : 4'd4; end
         default: begin wr = 1'b1; alu = 4'd7 + {2'b00, f}; end
      endcase
      model = {ir, ir_b, wr, src, alu, j, br, stk, fe, fp};
   endfunction

   function automatic logic [XLEN-1:0] mk(input logic [4:0] code);
      logic [26:0] r;
      r = 27'($urandom);
      mk = {code, r};
   endfunction

   task automatic idle(input int n);
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1; bus.ir = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({act(), bus.out_valid, bus.mul_busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_hold: got %h/%b/%b want all zero", act(), bus.out_valid, bus.mul_busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.mul_busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b mul_busy=%b want 1/0/0",
                  bus.in_ready, bus.out_valid, bus.mul_busy);
      end
      n_cmp++;
      if (act() !== '0) begin
         n_bad++;
         $display("FAIL reset_bundle: got %h want 0", act());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] prog [3];
      logic [5:0] chk [3];   // {alu, wr, stk}
      int idx;
      int pops;
      idx = 0; pops = 0;
      prog[0] = mk(5'b000_00); prog[1] = mk(5'b001_01); prog[2] = mk(5'b010_00);
      chk[0] = {4'd0, 1'b1, 1'b0}; chk[1] = {4'd0, 1'b0, 1'b1}; chk[2] = {4'd12, 1'b0, 1'b0};
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.ir = prog[0];
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.out_valid !== (c >= 1 && c <= 3)) begin
            n_bad++;
            $display("FAIL b2b_out_valid cyc%0d: got %b want %b", c, bus.out_valid, (c >= 1 && c <= 3));
         end
         if (c < 3) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_in_ready cyc%0d: got %b want 1", c, bus.in_ready);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0 || pops >= 3) begin
               n_bad++;
               $display("FAIL b2b_extra_output cyc%0d: got bundle %h want none", c, act());
            end else begin
               exp_b = sb_q.pop_front();
               if (act() !== exp_b) begin
                  n_bad++;
                  $display("FAIL b2b_bundle cyc%0d: got %h want %h", c, act(), exp_b);
               end
               n_cmp++;
               if ({bus.ALU_inst, bus.write_reg_en, bus.wr_en_stk} !== chk[pops]) begin
                  n_bad++;
                  $display("FAIL b2b_fields #%0d: got %b want %b", pops,
                           {bus.ALU_inst, bus.write_reg_en, bus.wr_en_stk}, chk[pops]);
               end
               pops++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(bus.ir));
            idx++;
         end
         @(posedge clk); #1;
         if (idx < 3) bus.ir = prog[idx];
         else bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_mul_stall();
      logic [4:0] ready_exp;
      logic [4:0] busy_exp;
      int idx;
      ready_exp = 5'b11001;   // bit c = cycle c
      busy_exp  = 5'b00110;
      idx = 0;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.ir = mk(5'b000_11);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.in_ready, bus.mul_busy} !== {ready_exp[c], busy_exp[c]}) begin
            n_bad++;
            $display("FAIL mul_stall cyc%0d: got in_ready=%b mul_busy=%b want %b/%b",
                     c, bus.in_ready, bus.mul_busy, ready_exp[c], busy_exp[c]);
         end
         if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL mul_extra_output cyc%0d: got %h want none", c, act());
            end else begin
               exp_b = sb_q.pop_front();
               if (act() !== exp_b) begin
                  n_bad++;
                  $display("FAIL mul_bundle cyc%0d: got %h want %h", c, act(), exp_b);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(bus.ir));
            idx++;
            n_cmp++;
            if (c != idx * 3 - 3) begin
               n_bad++;
               $display("FAIL mul_accept_cycle: got cyc%0d want cyc%0d", c, idx * 3 - 3);
            end
         end
         @(posedge clk); #1;
         if (idx == 1) bus.ir = mk(5'b000_00);
         else if (idx >= 2) bus.in_valid = 1'b0;
      end
      n_cmp++;
      if (idx != 2 || sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL mul_drain: got accepts=%0d pending=%0d want 2/0", idx, sb_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [XLEN-1:0] prog [3];
      int idx;
      int pops;
      idx = 0; pops = 0;
      prog[0] = mk(5'b000_01); prog[1] = mk(5'b110_00); prog[2] = mk(5'b111_10);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.ir = prog[0];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 4) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL bp_stall cyc%0d: got in_ready=%b out_valid=%b want 0/1",
                        c, bus.in_ready, bus.out_valid);
            end
            n_cmp++;
            if (sb_q.size() == 0 || act() !== sb_q[0]) begin
               n_bad++;
               $display("FAIL bp_hold cyc%0d: got %h want %h", c, act(),
                        (sb_q.size() == 0) ? '0 : sb_q[0]);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL bp_extra_output cyc%0d: got %h want none", c, act());
            end else begin
               exp_b = sb_q.pop_front();
               pops++;
               if (act() !== exp_b) begin
                  n_bad++;
                  $display("FAIL bp_bundle cyc%0d: got %h want %h", c, act(), exp_b);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(bus.ir));
            idx++;
         end
         @(posedge clk); #1;
         bus.out_ready = (c + 1 >= 5);
         if (idx < 3) bus.ir = prog[idx];
         else bus.in_valid = 1'b0;
      end
      n_cmp++;
      if (idx != 3 || pops != 3 || sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL bp_count: got accepts=%0d outputs=%0d pending=%0d want 3/3/0",
                  idx, pops, sb_q.size());
      end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b1; bus.ir = mk(5'b000_11);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_setup: got in_ready=%b want 1", bus.in_ready);
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.ir));
      @(posedge clk); #1;
      bus.ir = mk(5'b000_00);
      bus.flush = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.mul_busy, bus.in_ready} !== 3'b110) begin
         n_bad++;
         $display("FAIL flush_pre: got out_valid=%b mul_busy=%b in_ready=%b want 1/1/0",
                  bus.out_valid, bus.mul_busy, bus.in_ready);
      end
      sb_q.delete();
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.mul_busy, bus.in_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL flush_post: got out_valid=%b mul_busy=%b in_ready=%b want 0/0/1",
                  bus.out_valid, bus.mul_busy, bus.in_ready);
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.ir));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (!bus.out_valid || sb_q.size() != 1) begin
         n_bad++;
         $display("FAIL flush_resume: got out_valid=%b pending=%0d want 1/1", bus.out_valid, sb_q.size());
      end else begin
         exp_b = sb_q.pop_front();
         n_cmp++;
         if (act() !== exp_b) begin
            n_bad++;
            $display("FAIL flush_resume_bundle: got %h want %h", act(), exp_b);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep();
      int idx;
      int pops;
      logic [4:0] code;
      idx = 0; pops = 0;
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.ir = mk(5'd0);
      for (int c = 0; c < 150 && pops < 32; c++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL sweep_extra_output cyc%0d: got %h want none", c, act());
            end else begin
               exp_b = sb_q.pop_front();
               pops++;
               if (act() !== exp_b) begin
                  n_bad++;
                  $display("FAIL sweep_code%0d: got %h want %h", exp_b[BW-1 -: 5], act(), exp_b);
               end
               code = exp_b[BW-1 -: 5];
               if (code == 5'd31) begin
                  n_cmp++;
                  if (bus.ALU_inst !== 4'd10) begin
                     n_bad++;
                     $display("FAIL sweep_shift3_alu: got %0d want 10", bus.ALU_inst);
                  end
               end
               if (code == 5'd22) begin
                  n_cmp++;
                  if ({bus.flopinst, bus.fen} !== 3'b101) begin
                     n_bad++;
                     $display("FAIL sweep_fp2: got flopinst=%0d fen=%b want 2/1", bus.flopinst, bus.fen);
                  end
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(bus.ir));
            idx++;
         end
         @(posedge clk); #1;
         if (idx < 32) bus.ir = mk(5'(idx));
         else bus.in_valid = 1'b0;
      end
      n_cmp++;
      if (pops != 32 || sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL sweep_count: got outputs=%0d pending=%0d want 32/0", pops, sb_q.size());
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      bus.ir        = '0;
      test_reset();
      test_back_to_back();
      idle(2);
      test_mul_stall();
      idle(2);
      test_backpressure();
      idle(2);
      test_flush();
      idle(2);
      test_sweep();
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
